reg_access_arbiter: RTL and testbench
=====================================

Name: reg_access_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 32-bit storage register between NUM_REQ requesters. It accepts read and write requests on a req/ack handshake and grants one requester at a time. It drives the register's write-enable, read-enable and data-in pins, then captures the register output for reads. It sits between client blocks and the single register instance, which keeps its own clk/rst.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, register data width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester request
req_we  input  NUM_REQ  per-requester op select: 1=write, 0=read (valid while req high)
req_wdata  input  NUM_REQ*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W]
gnt  output  NUM_REQ  one-hot grant, held for the whole transaction
ack  output  NUM_REQ  one-cycle completion pulse to the granted requester
rdata  output  DATA_W  last read result, shared by all requesters
busy  output  1  high when state != IDLE
reg_wr_en  output  1  to register wr_en
reg_r_en  output  1  to register r_en
reg_data_in  output  DATA_W  to register data_in
reg_out  input  DATA_W  from register out

Behaviour:
- Clock and reset: one clock clk. Reset rst is asynchronous and active-high.
- While rst=1, all outputs are 0: gnt, ack, rdata, busy, reg_wr_en, reg_r_en and reg_data_in. Also state=IDLE and pointer ptr=0.
- All outputs are registered.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE, at a clock edge with req != 0:
  - Winner = first set bit searching ptr, ptr+1, ... wrapping at NUM_REQ-1 to 0.
  - Latch the winner index and its op.
  - Set gnt to one-hot(winner) and go to ACCESS.
  - For a write: reg_wr_en<=1 and reg_data_in<=winner's wdata.
  - For a read: reg_r_en<=1.
- ACCESS (1 cycle):
  - Write: reg_wr_en<=0, go to RESP.
  - Read: reg_r_en stays 1, go to CAPTURE.
- CAPTURE (read only, 1 cycle): rdata<=reg_out at the edge ending CAPTURE. reg_r_en<=0, go to RESP.
- RESP (1 cycle):
  - ack[winner]=1 for this cycle only; gnt is still held.
  - At the edge ending RESP: gnt<=0, ack<=0, ptr<=(winner+1) mod NUM_REQ, go to IDLE.
- Latency from the sampling edge to the ack cycle: write = 2 edges, read = 3 edges. There is one IDLE bubble between transactions, so throughput is 1 write per 3 cycles and 1 read per 4 cycles.
- reg_data_in holds its last value after a write and is never cleared except by reset.
- rdata changes only on read completion. Writes never alter it.
- A requester must hold req and req_we until ack. req_wdata need only be valid at the grant edge.
- Deasserting req after grant does not abort: the transaction completes and ack is still issued.
- A requester whose req is still high after its ack competes again with lowest priority.
- Requests arriving while busy wait. They are never lost and never granted mid-transaction.
- reg_wr_en and reg_r_en are never high together.
- Reset mid-transaction: outputs clear immediately (async), with no ack for the aborted request. The register contents are governed only by the register's own reset.

Decomposition:
- Shared package reg_arb_pkg:
  - state encoding constants: IDLE=2'd0, ACCESS=2'd1, CAPTURE=2'd2, RESP=2'd3
  - DATA_W default
  - op encoding: OP_WR=1, OP_RD=0
- Sub-module rr_pick: a combinational round-robin selector.
  - Inputs: req vector and ptr.
  - Outputs: one-hot grant, winner index and a valid flag.
  - Instantiated once in reg_access_arbiter. The FSM, pointer and datapath registers stay in the top.

Test Plan:
1. Assert rst=1 mid-simulation with random inputs -> gnt=0, ack=0, rdata=0, busy=0, reg_wr_en=0, reg_r_en=0 immediately. After release, all stay 0 with req=0.
2. req[1]=1, req_we[1]=1, wdata1=0xDEADBEEF -> gnt=4'b0010 after 1 edge; reg_wr_en high exactly 1 cycle with reg_data_in=0xDEADBEEF; ack[1] pulses 1 cycle later. Then req[2] read -> reg_r_en high 2 cycles, rdata=0xDEADBEEF, ack[2] pulse.
3. req=4'b1111, all writes with data 0x11,0x22,0x33,0x44 held until ack -> grants in order 0,1,2,3, each ack one-hot. Register ends at 0x44; read-back by req[0] returns 0x44.
4. Serve req[2] alone, then req[0] and req[3] together -> req[3] granted first (ptr=3), then req[0].
5. rst pulse during CAPTURE of a read by req[1] -> no ack[1] and rdata=0. After release, simultaneous req[0] and req[1] -> req[0] first (ptr=0).
6. req[0] dropped one cycle after grant -> the write still completes, ack[0] pulses, and busy returns to 0 the cycle after ack.

Source files
------------

// File: rtl/reg_arb_pkg.sv
// Shared encodings for the register access arbiter: FSM states, op select and
// the default data width.
package reg_arb_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic OP_WR = 1'b1;
  localparam logic OP_RD = 1'b0;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr_i,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] cand;
  int               sum;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    sum     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum  = int'(ptr_i) + k;
      cand = (sum >= NUM_REQ) ? IDX_W'(sum - NUM_REQ) : IDX_W'(sum);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin sequencer that shares one storage register between NUM_REQ
// requesters over a req/ack handshake; every output is registered.
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      reg_wr_en,
  output logic                      reg_r_en,
  output logic [DATA_W-1:0]         reg_data_in,
  input  logic [DATA_W-1:0]         reg_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_q;
  logic                op_q;
  logic [NUM_REQ-1:0]  gnt_q, ack_q;
  logic [DATA_W-1:0]   rdata_q, data_in_q;
  logic                busy_q, wr_en_q, r_en_q;

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;
  logic [DATA_W-1:0]   pick_wdata;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_wdata = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // The served requester drops to lowest priority for the next arbitration.
  assign ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      op_q      <= OP_RD;
      gnt_q     <= '0;
      ack_q     <= '0;
      rdata_q   <= '0;
      data_in_q <= '0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      r_en_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            win_q   <= pick_idx;
            op_q    <= req_we[pick_idx];
            gnt_q   <= pick_gnt;
            busy_q  <= 1'b1;
            state_q <= ACCESS;
            if (req_we[pick_idx] == OP_WR) begin
              wr_en_q   <= 1'b1;
              data_in_q <= pick_wdata;
            end else begin
              r_en_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (op_q == OP_WR) begin
            wr_en_q <= 1'b0;
            ack_q   <= gnt_q;
            state_q <= RESP;
          end else begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          rdata_q <= reg_out;
          r_en_q  <= 1'b0;
          ack_q   <= gnt_q;
          state_q <= RESP;
        end
        RESP: begin
          gnt_q   <= '0;
          ack_q   <= '0;
          ptr_q   <= ptr_d;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_r_en    = r_en_q;
  assign reg_data_in = data_in_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a behavioural storage register
// (write on wr_en, registered read on r_en).
module tb_reg_access_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N-1:0]      gnt, ack;
  logic [DW-1:0]     rdata, reg_data_in;
  logic              busy, reg_wr_en, reg_r_en;
  logic [DW-1:0]     reg_mem = '0;
  logic [DW-1:0]     reg_out = '0;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] last_rd = '0;

  reg_access_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_we      (req_we),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .ack         (ack),
    .rdata       (rdata),
    .busy        (busy),
    .reg_wr_en   (reg_wr_en),
    .reg_r_en    (reg_r_en),
    .reg_data_in (reg_data_in),
    .reg_out     (reg_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reg_wr_en) reg_mem <= reg_data_in;
    if (reg_r_en)  reg_out <= reg_mem;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) check("wr_rd_exclusive", DW'(reg_wr_en & reg_r_en), '0);
  end

  task automatic check_idle(input string name);
    check(name, DW'({busy, reg_wr_en, reg_r_en, ack, gnt}), '0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, DW'({busy, reg_wr_en, reg_r_en, ack, gnt}), '0);
    check({name, "_rdata"}, rdata, '0);
    check({name, "_din"}, reg_data_in, '0);
  endtask

  // One isolated transaction with cycle-exact checks; starts and ends at a negedge.
  task automatic run_single(input int idx, input logic we, input logic [DW-1:0] wd,
                            input logic [DW-1:0] exp_rd);
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    @(negedge clk);
    req[idx] = 1'b1;
    req_we[idx] = we;
    req_wdata[idx*DW +: DW] = wd;
    @(negedge clk);
    check("grant", DW'(gnt), DW'(oh));
    check("busy", DW'(busy), 1);
    check("wr_en", DW'(reg_wr_en), DW'(we));
    check("r_en", DW'(reg_r_en), DW'(!we));
    if (we) check("data_in", reg_data_in, wd);
    if (we) begin
      @(negedge clk);
      check("wr_ack", DW'(ack), DW'(oh));
      check("wr_en_off", DW'(reg_wr_en), 0);
      check("wr_gnt_held", DW'(gnt), DW'(oh));
      check("rdata_kept", rdata, last_rd);
    end else begin
      @(negedge clk);
      check("rd_no_ack_yet", DW'(ack), 0);
      check("r_en_hold", DW'(reg_r_en), 1);
      @(negedge clk);
      check("rd_ack", DW'(ack), DW'(oh));
      check("r_en_off", DW'(reg_r_en), 0);
      check("rdata", rdata, exp_rd);
      last_rd = exp_rd;
    end
    req[idx] = 1'b0;
    req_we[idx] = 1'b0;
    @(negedge clk);
    check_idle("back_idle");
  endtask

  typedef struct {
    int          idx;
    logic        we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{idx: 1, we: 1'b1, wdata: 32'hDEAD_BEEF, exp_rdata: 32'h0};
    vecs[1] = '{idx: 2, we: 1'b0, wdata: 32'h0,         exp_rdata: 32'hDEAD_BEEF};
    vecs[2] = '{idx: 3, we: 1'b1, wdata: 32'h1234_5678, exp_rdata: 32'h0};
    vecs[3] = '{idx: 0, we: 1'b0, wdata: 32'h0,         exp_rdata: 32'h1234_5678};
    vecs[4] = '{idx: 2, we: 1'b1, wdata: 32'hA5A5_A5A5, exp_rdata: 32'h0};
    vecs[5] = '{idx: 1, we: 1'b0, wdata: 32'h0,         exp_rdata: 32'hA5A5_A5A5};

    #2 rst = 1'b1;
    #1 check_all_zero("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_por");

    // Single transactions from the table.
    foreach (vecs[v]) run_single(vecs[v].idx, vecs[v].we, vecs[v].wdata, vecs[v].exp_rdata);

    // Async reset in the middle of random traffic.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req = N'($urandom);
      req_we = N'($urandom);
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    req = '0;
    req_we = '0;
    rst = 1'b0;
    last_rd = '0;
    repeat (2) @(negedge clk);
    check_all_zero("after_rst");

    // All four write at once: served 0,1,2,3 with ptr starting at 0.
    @(negedge clk);
    req = 4'b1111;
    req_we = 4'b1111;
    req_wdata = {32'h44, 32'h33, 32'h22, 32'h11};
    for (int k = 0; k < N; k++) begin
      logic found;
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        @(negedge clk);
        if (ack != '0) found = 1'b1;
      end
      check("rr_order_ack", found ? DW'(ack) : '0, DW'(N'(1) << k));
      req[k] = 1'b0;
      req_we[k] = 1'b0;
    end
    @(negedge clk);
    check_idle("rr_idle");
    run_single(0, 1'b0, '0, 32'h44);

    // Pointer after serving 2 is 3: req 3 wins over req 0.
    run_single(2, 1'b1, 32'h55, '0);
    @(negedge clk);
    req = 4'b1001;
    req_we = '0;
    @(negedge clk);
    check("ptr3_first", DW'(gnt), 32'b1000);
    repeat (2) @(negedge clk);
    check("ptr3_ack", DW'(ack), 32'b1000);
    check("ptr3_rdata", rdata, 32'h55);
    req[3] = 1'b0;
    @(negedge clk);
    check("ptr3_gap", DW'(gnt), 0);
    @(negedge clk);
    check("ptr0_next", DW'(gnt), 32'b0001);
    repeat (2) @(negedge clk);
    check("ptr0_ack", DW'(ack), 32'b0001);
    req[0] = 1'b0;
    @(negedge clk);
    check_idle("t4_idle");

    // Reset during CAPTURE of a read by requester 1.
    @(negedge clk);
    req[1] = 1'b1;
    req_we[1] = 1'b0;
    @(negedge clk);
    check("t5_gnt", DW'(gnt), 32'b0010);
    @(negedge clk);
    check("t5_capture_r_en", DW'(reg_r_en), 1);
    #2 rst = 1'b1;
    #1 check_all_zero("capture_rst");
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0011;
    req_we = '0;
    last_rd = '0;
    @(negedge clk);
    check("t5_ptr0", DW'(gnt), 32'b0001);
    repeat (2) @(negedge clk);
    check("t5_ack0", DW'(ack), 32'b0001);
    check("t5_rdata0", rdata, 32'h55);
    req[0] = 1'b0;
    @(negedge clk);
    check("t5_gap", DW'(gnt), 0);
    @(negedge clk);
    check("t5_gnt1", DW'(gnt), 32'b0010);
    repeat (2) @(negedge clk);
    check("t5_ack1", DW'(ack), 32'b0010);
    req[1] = 1'b0;
    last_rd = 32'h55;
    @(negedge clk);
    check_idle("t5_idle");

    // req dropped right after grant: the write still completes.
    @(negedge clk);
    req[0] = 1'b1;
    req_we[0] = 1'b1;
    req_wdata[31:0] = 32'h66;
    @(negedge clk);
    check("t6_gnt", DW'(gnt), 32'b0001);
    req[0] = 1'b0;
    req_we[0] = 1'b0;
    @(negedge clk);
    check("t6_ack", DW'(ack), 32'b0001);
    check("t6_rdata_kept", rdata, 32'h55);
    @(negedge clk);
    check_idle("t6_busy_drop");
    run_single(3, 1'b0, '0, 32'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
